// File: rtl/pcie_tx_arb_pkg.sv
// rtl/pcie_tx_arb_pkg.sv - shared types and constants for the PCIe TX arbiter
package pcie_tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam logic SRC_PIO = 1'b0;
    localparam logic SRC_INJ = 1'b1;

    localparam int TX_DATA_WIDTH = 64;
    localparam int TX_KEEP_WIDTH = TX_DATA_WIDTH / 8;
    localparam int TX_USER_WIDTH = 4;

    typedef struct packed {
        logic                     tvalid;
        logic                     tlast;
        logic [TX_KEEP_WIDTH-1:0] tkeep;
        logic [TX_DATA_WIDTH-1:0] tdata;
        logic [TX_USER_WIDTH-1:0] tuser;
    } axis_tx_beat_t;

    // A weight of zero would starve the port, so it behaves as one.
    function automatic int eff_weight(input int w);
        return (w <= 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/pcie_tx_arbiter.sv
// rtl/pcie_tx_arbiter.sv - packet-granular weighted round-robin arbiter for the PCIe core TX port
module pcie_tx_arbiter
    import pcie_tx_arb_pkg::*;
#(
    parameter int C_DATA_WIDTH = 64,
    parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8,
    parameter int W0           = 4,
    parameter int W1           = 4
) (
    input  logic                    pcie_clk,
    input  logic                    pcie_rst_n,
    input  logic                    s0_tvalid,
    output logic                    s0_tready,
    input  logic                    s0_tlast,
    input  logic [KEEP_WIDTH-1:0]   s0_tkeep,
    input  logic [C_DATA_WIDTH-1:0] s0_tdata,
    input  logic [3:0]              s0_tuser,
    input  logic                    s1_tvalid,
    output logic                    s1_tready,
    input  logic                    s1_tlast,
    input  logic [KEEP_WIDTH-1:0]   s1_tkeep,
    input  logic [C_DATA_WIDTH-1:0] s1_tdata,
    input  logic [3:0]              s1_tuser,
    output logic                    m_tvalid,
    input  logic                    m_tready,
    output logic                    m_tlast,
    output logic [KEEP_WIDTH-1:0]   m_tkeep,
    output logic [C_DATA_WIDTH-1:0] m_tdata,
    output logic [3:0]              m_tuser,
    output logic [1:0]              grant,
    output logic                    busy,
    output logic [31:0]             stat_pkt0,
    output logic [31:0]             stat_pkt1
);

    localparam int W0_EFF  = eff_weight(W0);
    localparam int W1_EFF  = eff_weight(W1);
    localparam int CNT_MAX = (W0_EFF > W1_EFF) ? W0_EFF : W1_EFF;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W:0] W0_LIM = W0_EFF[CNT_W:0];
    localparam logic [CNT_W:0] W1_LIM = W1_EFF[CNT_W:0];

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   cnt_inc;
    logic             last_q, last_d;
    logic             busy_q;
    logic [31:0]      stat_pkt0_q, stat_pkt1_q;
    logic             sel1;
    logic             xfer, eop;

    // Datapath follows the owner combinationally; IDLE shows source 0 but never valid.
    assign sel1    = (state_q == GNT1);
    assign m_tlast = sel1 ? s1_tlast : s0_tlast;
    assign m_tkeep = sel1 ? s1_tkeep : s0_tkeep;
    assign m_tdata = sel1 ? s1_tdata : s0_tdata;
    assign m_tuser = sel1 ? s1_tuser : s0_tuser;

    always_comb begin
        grant     = 2'b00;
        m_tvalid  = 1'b0;
        s0_tready = 1'b0;
        s1_tready = 1'b0;
        case (state_q)
            GNT0: begin
                grant     = 2'b01;
                m_tvalid  = s0_tvalid;
                s0_tready = m_tready;
            end
            GNT1: begin
                grant     = 2'b10;
                m_tvalid  = s1_tvalid;
                s1_tready = m_tready;
            end
            default: ;
        endcase
    end

    assign xfer      = m_tvalid & m_tready;
    assign eop       = xfer & m_tlast;
    assign cnt_inc   = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    assign busy      = busy_q;
    assign stat_pkt0 = stat_pkt0_q;
    assign stat_pkt1 = stat_pkt1_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (s0_tvalid && (!s1_tvalid || last_q == SRC_INJ)) begin
                    state_d = GNT0;
                    cnt_d   = '0;
                end else if (s1_tvalid) begin
                    state_d = GNT1;
                    cnt_d   = '0;
                end
            end
            GNT0: begin
                if (eop) begin
                    last_d = SRC_PIO;
                    if (cnt_inc >= W0_LIM) begin
                        cnt_d = '0;
                        if (s1_tvalid) state_d = GNT1;
                    end else begin
                        cnt_d = cnt_inc[CNT_W-1:0];
                    end
                end else if (!busy_q && !s0_tvalid) begin
                    cnt_d   = '0;
                    state_d = s1_tvalid ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (eop) begin
                    last_d = SRC_INJ;
                    if (cnt_inc >= W1_LIM) begin
                        cnt_d = '0;
                        if (s0_tvalid) state_d = GNT0;
                    end else begin
                        cnt_d = cnt_inc[CNT_W-1:0];
                    end
                end else if (!busy_q && !s1_tvalid) begin
                    cnt_d   = '0;
                    state_d = s0_tvalid ? GNT0 : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
        if (!pcie_rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            last_q      <= SRC_INJ;
            busy_q      <= 1'b0;
            stat_pkt0_q <= '0;
            stat_pkt1_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            if (xfer) busy_q <= ~m_tlast;
            if (eop && state_q == GNT0) stat_pkt0_q <= stat_pkt0_q + 32'd1;
            if (eop && state_q == GNT1) stat_pkt1_q <= stat_pkt1_q + 32'd1;
        end
    end

endmodule

// File: tb/tb_pcie_tx_arbiter.sv
// tb/tb_pcie_tx_arbiter.sv - directed self-checking bench for pcie_tx_arbiter
module tb_pcie_tx_arbiter;

    localparam int DW = 64;
    localparam int KW = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s0_tvalid, s0_tready, s0_tlast;
    logic [KW-1:0] s0_tkeep;
    logic [DW-1:0] s0_tdata;
    logic [3:0]    s0_tuser;
    logic          s1_tvalid, s1_tready, s1_tlast;
    logic [KW-1:0] s1_tkeep;
    logic [DW-1:0] s1_tdata;
    logic [3:0]    s1_tuser;
    logic          m_tvalid, m_tready, m_tlast;
    logic [KW-1:0] m_tkeep;
    logic [DW-1:0] m_tdata;
    logic [3:0]    m_tuser;
    logic [1:0]    grant;
    logic          busy;
    logic [31:0]   stat_pkt0, stat_pkt1;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pcie_tx_arbiter dut (
        .pcie_clk(clk), .pcie_rst_n(rst_n),
        .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_tlast(s0_tlast),
        .s0_tkeep(s0_tkeep), .s0_tdata(s0_tdata), .s0_tuser(s0_tuser),
        .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_tlast(s1_tlast),
        .s1_tkeep(s1_tkeep), .s1_tdata(s1_tdata), .s1_tuser(s1_tuser),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tlast(m_tlast),
        .m_tkeep(m_tkeep), .m_tdata(m_tdata), .m_tuser(m_tuser),
        .grant(grant), .busy(busy), .stat_pkt0(stat_pkt0), .stat_pkt1(stat_pkt1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int i0, i1, o0, o1, open, src, cyc;
        logic [63:0] exp_d;

        s0_tvalid = 1'b1; s0_tlast = 1'b1; s0_tkeep = '1; s0_tdata = '0; s0_tuser = 4'h0;
        s1_tvalid = 1'b0; s1_tlast = 1'b0; s1_tkeep = '1; s1_tdata = '0; s1_tuser = 4'h0;
        m_tready  = 1'b1;

        // reset state, with source 0 already requesting
        repeat (2) @(negedge clk);
        #1;
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_grant", grant, 0);
        chk("rst_busy", busy, 0);
        chk("rst_s0_tready", s0_tready, 0);
        chk("rst_stat0", stat_pkt0, 0);
        chk("rst_stat1", stat_pkt1, 0);

        // source 0 only: three 3-beat TLPs
        @(negedge clk);
        rst_n = 1'b1;
        s0_tvalid = 1'b1; s0_tdata = 64'hA000; s0_tlast = 1'b0;
        #1 chk("t1_bubble", m_tvalid, 0);
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            s0_tdata = 64'hA000 + 64'(k);
            s0_tlast = (k % 3 == 2);
            #1;
            chk("t1_valid", m_tvalid, 1);
            chk("t1_data", m_tdata, 64'hA000 + 64'(k));
            chk("t1_grant", grant, 2'b01);
        end
        @(negedge clk);
        s0_tvalid = 1'b0;
        #1;
        chk("t1_stat0", stat_pkt0, 3);
        chk("t1_stat1", stat_pkt1, 0);
        chk("t1_busy", busy, 0);
        @(negedge clk);
        #1 chk("t1_idle_grant", grant, 0);

        // both sources valid, single-beat TLPs, weights 4/4
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        s0_tvalid = 1'b1; s0_tlast = 1'b1; s0_tdata = 64'h5555;
        s1_tvalid = 1'b1; s1_tlast = 1'b1; s1_tdata = 64'h6666;
        #1 chk("t2_bubble", m_tvalid, 0);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            #1;
            chk("t2_grant", grant, ((i / 4) % 2 == 0) ? 2'b01 : 2'b10);
            chk("t2_valid", m_tvalid, 1);
            chk("t2_data", m_tdata, ((i / 4) % 2 == 0) ? 64'h5555 : 64'h6666);
        end
        @(negedge clk);
        s0_tvalid = 1'b0; s1_tvalid = 1'b0;
        #1;
        chk("t2_stat0", stat_pkt0, 8);
        chk("t2_stat1", stat_pkt1, 4);

        // source 0 stalls mid-TLP while source 1 waits
        @(negedge clk);
        s0_tvalid = 1'b1; s0_tlast = 1'b0; s0_tdata = 64'hC0;
        #1 chk("t3_bubble", m_tvalid, 0);
        @(negedge clk);
        s1_tvalid = 1'b1; s1_tlast = 1'b1; s1_tdata = 64'hD0; s1_tuser = 4'h9;
        #1;
        chk("t3_grant0", grant, 2'b01);
        chk("t3_s0_tready", s0_tready, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            s0_tvalid = 1'b0;
            #1;
            chk("t3_hold_grant", grant, 2'b01);
            chk("t3_s1_blocked", s1_tready, 0);
            chk("t3_busy", busy, 1);
        end
        @(negedge clk);
        s0_tvalid = 1'b1; s0_tlast = 1'b1; s0_tdata = 64'hC1;
        #1;
        chk("t3_tlast", m_tlast, 1);
        chk("t3_tlast_data", m_tdata, 64'hC1);
        chk("t3_s1_still_blocked", s1_tready, 0);
        @(negedge clk);
        s0_tvalid = 1'b0;
        #1;
        chk("t3_after_eop_grant", grant, 2'b01);
        chk("t3_after_eop_busy", busy, 0);
        @(negedge clk);
        #1;
        chk("t3_switch_grant", grant, 2'b10);
        chk("t3_s1_tready", s1_tready, 1);
        chk("t3_s1_data", m_tdata, 64'hD0);
        chk("t3_s1_tuser", m_tuser, 4'h9);
        @(negedge clk);
        s1_tvalid = 1'b0;
        #1;
        chk("t3_stat0", stat_pkt0, 9);
        chk("t3_stat1", stat_pkt1, 5);

        // random back-pressure, both sources sending three 5-beat TLPs
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        i0 = 0; i1 = 0; o0 = 0; o1 = 0; open = -1; cyc = 0;
        while ((i0 < 15 || i1 < 15) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            m_tready  = 1'($urandom_range(0, 1));
            s0_tvalid = (i0 < 15);
            s0_tdata  = 64'h0A00_0000_0000_0000 | 64'(i0);
            s0_tlast  = (i0 % 5 == 4);
            s1_tvalid = (i1 < 15);
            s1_tdata  = 64'h0B00_0000_0000_0000 | 64'(i1);
            s1_tlast  = (i1 % 5 == 4);
            #1;
            if (m_tvalid && m_tready) begin
                src = grant[1] ? 1 : 0;
                if (open != -1) chk("t4_interleave", 64'(src), 64'(open));
                exp_d = (src == 1) ? (64'h0B00_0000_0000_0000 | 64'(o1))
                                   : (64'h0A00_0000_0000_0000 | 64'(o0));
                chk("t4_data", m_tdata, exp_d);
                if (src == 1) o1++; else o0++;
                open = m_tlast ? -1 : src;
            end
            if (s0_tvalid && s0_tready) i0++;
            if (s1_tvalid && s1_tready) i1++;
        end
        @(negedge clk);
        s0_tvalid = 1'b0; s1_tvalid = 1'b0; m_tready = 1'b1;
        #1;
        chk("t4_src0_done", 64'(i0), 15);
        chk("t4_src1_done", 64'(i1), 15);
        chk("t4_out0_beats", 64'(o0), 15);
        chk("t4_out1_beats", 64'(o1), 15);
        chk("t4_stat0", stat_pkt0, 3);
        chk("t4_stat1", stat_pkt1, 3);

        // reset during beat 2 of a 4-beat source 1 TLP
        @(negedge clk);
        s1_tvalid = 1'b1; s1_tlast = 1'b0; s1_tdata = 64'hE0;
        #1 chk("t5_bubble", m_tvalid, 0);
        @(negedge clk);
        #1 chk("t5_grant1", grant, 2'b10);
        @(negedge clk);
        s1_tdata = 64'hE1;
        #1;
        chk("t5_busy_before", busy, 1);
        chk("t5_valid_before", m_tvalid, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", m_tvalid, 0);
        chk("t5_rst_grant", grant, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_s1_tready", s1_tready, 0);
        chk("t5_rst_stat0", stat_pkt0, 0);
        chk("t5_rst_stat1", stat_pkt1, 0);
        @(negedge clk);
        rst_n = 1'b1;
        s1_tvalid = 1'b0;
        s0_tvalid = 1'b1; s0_tlast = 1'b1; s0_tdata = 64'hF0;
        #1 chk("t5_new_bubble", m_tvalid, 0);
        @(negedge clk);
        #1;
        chk("t5_new_grant", grant, 2'b01);
        chk("t5_new_data", m_tdata, 64'hF0);
        chk("t5_new_s0_tready", s0_tready, 1);
        @(negedge clk);
        s0_tvalid = 1'b0;
        #1 chk("t5_new_stat0", stat_pkt0, 1);

        // stat counter wrap
        @(negedge clk);
        dut.stat_pkt0_q = 32'hFFFF_FFFF;
        s0_tvalid = 1'b1; s0_tlast = 1'b1; s0_tdata = 64'hF1;
        #1 chk("t6_preset", stat_pkt0, 32'hFFFF_FFFF);
        @(negedge clk);
        #1 chk("t6_grant", grant, 2'b01);
        @(negedge clk);
        s0_tvalid = 1'b0;
        #1;
        chk("t6_wrap", stat_pkt0, 0);
        chk("t6_stat1", stat_pkt1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
